// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter: FSM state encoding, header default and the
// round-robin pick function used by the priority encoder.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StData
  } arb_state_e;

  localparam logic [7:0] HEADER_BASE_DEFAULT = 8'hA0;
  localparam int unsigned MAX_CH = 8;

  // First set bit scanning last+1, last+2, ... modulo num_ch; returns last when nothing is set.
  function automatic logic [2:0] rr_pick(input logic [MAX_CH-1:0] req,
                                         input logic [2:0]        last,
                                         input int unsigned       num_ch);
    logic [2:0] pick;
    int         idx;
    pick = last;
    // Walk from the farthest candidate inward so the nearest requester wins.
    for (int k = int'(num_ch); k >= 1; k--) begin
      idx = (int'(last) + k) % int'(num_ch);
      if (req[idx[2:0]]) pick = idx[2:0];
    end
    return pick;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle for the UART TX arbiter: NUM_CH requester streams in, one byte stream out.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_CH = 4
);

  logic [NUM_CH*8-1:0] s_axis_tdata;
  logic [NUM_CH-1:0]   s_axis_tvalid;
  logic [NUM_CH-1:0]   s_axis_tlast;
  logic [NUM_CH-1:0]   s_axis_tready;
  logic [7:0]          m_axis_tdata;
  logic                m_axis_tvalid;
  logic                m_axis_tready;

  // Arbiter side.
  modport master (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    input  s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready
  );

  // Requesters plus UART TX side.
  modport slave (
    output s_axis_tdata,
    output s_axis_tvalid,
    output s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready
  );

endinterface

// File: rtl/uart_arb_rr_picker.sv
// Combinational round-robin priority encoder: next requester after the last granted channel.
module uart_arb_rr_picker
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [2:0]        last_i,
  output logic [2:0]        pick_o,
  output logic              any_o
);

  logic [MAX_CH-1:0] req_ext;

  always_comb begin
    req_ext             = '0;
    req_ext[NUM_CH-1:0] = req_i;
    pick_o              = rr_pick(req_ext, last_i, NUM_CH);
    any_o               = |req_i;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX byte port among NUM_CH byte streams,
// with an optional channel-ID header byte in front of every granted packet.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned MAX_LEN     = 64,
  parameter bit          HEADER_EN   = 1'b1,
  parameter logic [7:0]  HEADER_BASE = HEADER_BASE_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  uart_tx_arbiter_if.master        bus,
  output logic [2:0]               grant_id,
  output logic                     busy,
  output logic                     err_overlen
);

  localparam int unsigned CntW = $clog2(MAX_LEN + 1);

  arb_state_e      state_q;
  logic [2:0]      grant_q;
  logic [2:0]      last_q;
  logic [CntW-1:0] cnt_q;
  logic [7:0]      out_data_q;
  logic            out_valid_q;
  logic            err_q;

  logic            can_load;
  logic            beat_ok;
  logic            beat_last;
  logic [7:0]      beat_data;
  logic            cnt_full;
  logic [2:0]      pick;
  logic            pick_any;

  uart_arb_rr_picker #(
    .NUM_CH (NUM_CH)
  ) u_picker (
    .req_i  (bus.s_axis_tvalid),
    .last_i (last_q),
    .pick_o (pick),
    .any_o  (pick_any)
  );

  // The output register accepts a new byte when empty or when it drains this cycle.
  assign can_load  = !out_valid_q || bus.m_axis_tready;
  assign beat_data = bus.s_axis_tdata[{grant_q, 3'b000} +: 8];
  assign beat_last = bus.s_axis_tlast[grant_q];
  assign beat_ok   = (state_q == StData) && can_load && bus.s_axis_tvalid[grant_q];
  assign cnt_full  = (cnt_q == CntW'(MAX_LEN - 1));

  always_comb begin
    bus.s_axis_tready = '0;
    if (state_q == StData) bus.s_axis_tready[grant_q] = can_load;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      last_q      <= 3'(NUM_CH - 1);
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (out_valid_q && bus.m_axis_tready) out_valid_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (pick_any) begin
            grant_q <= pick;
            state_q <= HEADER_EN ? StHdr : StData;
          end
        end

        StHdr: begin
          if (can_load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= HEADER_BASE | {5'b00000, grant_q};
            state_q     <= StData;
          end
        end

        StData: begin
          if (beat_ok) begin
            out_valid_q <= 1'b1;
            out_data_q  <= beat_data;
            if (beat_last || cnt_full) begin
              // tlast on the MAX_LEN-th beat is an ordinary end of packet.
              state_q <= StIdle;
              last_q  <= grant_q;
              cnt_q   <= '0;
              err_q   <= cnt_full && !beat_last;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.m_axis_tdata  = out_data_q;
  assign bus.m_axis_tvalid = out_valid_q;
  assign grant_id          = grant_q;
  assign busy              = (state_q != StIdle);
  assign err_overlen       = err_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter byte port among NUM_CH independent AXI-stream byte requesters. Arbitration is round-robin and packet-granular: a grant is held until the requester's tlast beat or until MAX_LEN beats, whichever comes first. An optional channel-ID header byte is sent ahead of each packet. The block sits between the per-source streams and the UART TX s_axis_* input.

Parameters:
NUM_CH, 4, number of requesters (2..8)
MAX_LEN, 64, max beats per grant before forced release (≥2)
HEADER_EN, 1, 1 = emit header byte before each packet
HEADER_BASE, 8'hA0, header byte = HEADER_BASE | grant index (index in low 3 bits)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
s_axis_tdata  in  NUM_CH*8  channel i occupies bits [8i+7:8i]
s_axis_tvalid  in  NUM_CH  per-channel valid
s_axis_tlast  in  NUM_CH  per-channel end of packet
s_axis_tready  out  NUM_CH  per-channel ready; at most one bit high
m_axis_tdata  out  8  byte to UART TX
m_axis_tvalid  out  1  byte valid to UART TX
m_axis_tready  in  1  UART TX ready
grant_id  out  3  currently granted channel; valid while busy=1
busy  out  1  high in HDR or DATA state
err_overlen  out  1  one-cycle pulse on forced release at MAX_LEN

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, last_grant=NUM_CH-1 (channel 0 has first priority), output register empty, pkt_cnt=0, all outputs 0.
- Output stage: single registered entry (m_axis_tdata/tvalid). Loads when empty, or when it is emptying the same cycle (m_axis_tvalid & m_axis_tready). Clears on handshake with no reload. m_axis_tdata is held stable while m_axis_tvalid=1 and m_axis_tready=0.
- IDLE: if any s_axis_tvalid bit is set, grant the first valid channel scanning last_grant+1, last_grant+2, … modulo NUM_CH. Latch grant_id. Go to HDR if HEADER_EN, else DATA. No s_axis_tready in IDLE.
- HDR: when the output stage can load, load HEADER_BASE|grant_id and go to DATA. No input beat is accepted in HDR.
- DATA: s_axis_tready[grant_id] = output stage can load; all other ready bits are 0. An accepted beat loads the output stage and increments pkt_cnt. The beat appears on m_axis_tvalid in the next cycle (1-cycle latency).
- Release: on an accepted beat with tlast=1, or with pkt_cnt reaching MAX_LEN (whichever first), go to IDLE, set last_grant=grant_id, and clear pkt_cnt. If the release is due to MAX_LEN with tlast=0, pulse err_overlen. Any remainder of that packet re-arbitrates as a new packet and gets a new header.
- Back-to-back: IDLE lasts exactly 1 cycle when requests are pending. Bubble per packet is 1 cycle plus the header.
- Valid de-asserted by the granted channel mid-packet: grant is held (no timeout) and the block waits.
- Simultaneous tlast and MAX_LEN: treated as a normal release, no err_overlen.
- Requests from non-granted channels are ignored until IDLE. Their valid/data need not be stable.
- rst low mid-packet: immediate return to reset state. Any byte in the output stage is dropped (m_axis_tvalid=0 next cycle).
- Prescale configuration of the UART is outside this block.

Decomposition:
- Package uart_arb_pkg:
  - state enum IDLE/HDR/DATA
  - HEADER_BASE default
  - function rr_pick(req, last) returning the next index
- One natural sub-module: uart_arb_rr_picker (combinational round-robin priority encoder, parameterised NUM_CH). It is instantiated once.
- Everything else is in the top.

Test Plan:
All tests: UART TX attached with prescale=6 (48 clk/bit, 480 clk/frame), except test 4.
1. Reset/idle: rst=0 for 4 cycles, then 1 with no requests -> all outputs 0, busy=0, txd idle high.
2. Single packet: ch2 sends {8'h11, 8'h22(tlast)} -> UART bytes A2, 11, 22 in order. err_overlen never pulses. busy falls the cycle after the 22 handshake.
3. Round-robin fairness: ch0, ch1 and ch3 each hold 2-byte packets continuously -> headers A0, A1, A3, A0, A1, A3, … No channel is granted twice while another waits.
4. Back-pressure: m_axis_tready toggles 1-on/3-off with a UART model (no real TX), ch1 sends 5 bytes -> every byte is delivered once and in order. m_axis_tdata is stable while stalled. s_axis_tready[1] is 0 whenever the output register is full.
5. Overlength: MAX_LEN=4, ch0 sends 6 beats with tlast only on beat 6 -> err_overlen pulses once with beat 4. Stream is A0, b1..b4, A0, b5, b6.
6. Mid-packet reset: assert rst=0 after 2 data bytes of a ch3 packet -> next cycle m_axis_tvalid=0, s_axis_tready=0, busy=0. After release, ch1 is granted first if ch1 and ch3 both request (last_grant reset to NUM_CH-1, so priority starts at 0).
